// File: rtl/dmem_if.sv
// dmem_if: LSU data-memory bundle with tagged loads and single-outstanding stores
interface dmem_if #(
  parameter int unsigned LDTAG_W = 4
);
  logic               ld_valid;
  logic               ld_ready;
  logic [31:0]        ld_addr;
  logic [2:0]         ld_size;
  logic [LDTAG_W-1:0] ld_tag;
  logic               ld_resp_valid;
  logic               ld_resp_ready;
  logic [LDTAG_W-1:0] ld_resp_tag;
  logic [63:0]        ld_resp_data;
  logic               ld_resp_err;
  logic               st_valid;
  logic               st_ready;
  logic [31:0]        st_addr;
  logic [2:0]         st_size;
  logic [63:0]        st_wdata;
  logic [7:0]         st_wstrb;
  logic               st_resp_valid;
  logic               st_resp_ready;
  modport master (
    output ld_valid, ld_addr, ld_size, ld_tag, ld_resp_ready,
           st_valid, st_addr, st_size, st_wdata, st_wstrb, st_resp_ready,
    input  ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_data, ld_resp_err,
           st_ready, st_resp_valid
  );
  modport slave (
    input  ld_valid, ld_addr, ld_size, ld_tag, ld_resp_ready,
           st_valid, st_addr, st_size, st_wdata, st_wstrb, st_resp_ready,
    output ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_data, ld_resp_err,
           st_ready, st_resp_valid
  );
endinterface

// File: rtl/dmem_slave_mem.sv
// dmem_slave_mem: byte-strobed 64-bit memory serving fixed-latency in-order loads and handshaked stores
module dmem_slave_mem #(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LDTAG_W    = 4,
  parameter int unsigned LD_LATENCY = 2,
  parameter int unsigned LD_DEPTH   = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  dmem_if.slave   dmem
);
  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / 8;
  localparam int unsigned PW    = $clog2(LD_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam logic [3:0]  AGE_MAX = 4'(LD_LATENCY);
  typedef enum logic {S_IDLE, S_RESP} state_t;
  logic [63:0]        mem [WORDS];
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  state_t             state_q, state_d;
  logic [LDTAG_W-1:0] tag_q [LD_DEPTH];
  logic [LDTAG_W-1:0] tag_d [LD_DEPTH];
  logic               err_q [LD_DEPTH];
  logic               err_d [LD_DEPTH];
  logic [63:0]        data_q [LD_DEPTH];
  logic [63:0]        data_d [LD_DEPTH];
  logic [3:0]         age_q [LD_DEPTH];
  logic [3:0]         age_d [LD_DEPTH];
  logic [31:0]        ld_off, st_off;
  logic [2:0]         ld_mask;
  logic               ld_in, st_in, ld_bad, push, pop, head_vld, st_we;
  assign ld_off  = dmem.ld_addr - BASE_ADDR;
  assign st_off  = dmem.st_addr - BASE_ADDR;
  assign ld_in   = ld_off < 32'(MEM_BYTES);
  assign st_in   = st_off < 32'(MEM_BYTES);
  assign ld_mask = 3'((4'd1 << dmem.ld_size[1:0]) - 4'd1);
  assign ld_bad  = !ld_in || dmem.ld_size[2] || |(ld_off[2:0] & ld_mask);
  assign push     = dmem.ld_valid && dmem.ld_ready;
  assign pop      = head_vld && dmem.ld_resp_ready;
  assign head_vld = (cnt_q != '0) && (age_q[rptr_q] == AGE_MAX);
  assign dmem.ld_ready      = cnt_q != CW'(LD_DEPTH);
  assign dmem.ld_resp_valid = head_vld;
  // Payload is gated so stale queue contents never leak out while empty or after reset
  assign dmem.ld_resp_tag   = head_vld ? tag_q[rptr_q] : '0;
  assign dmem.ld_resp_data  = head_vld ? data_q[rptr_q] : '0;
  assign dmem.ld_resp_err   = head_vld ? err_q[rptr_q] : 1'b0;
  assign dmem.st_ready      = state_q == S_IDLE;
  assign dmem.st_resp_valid = state_q == S_RESP;
  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    tag_d  = tag_q;
    err_d  = err_q;
    data_d = data_q;
    for (int i = 0; i < LD_DEPTH; i++)
      age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + 4'd1;
    if (push) begin
      tag_d[wptr_q]  = dmem.ld_tag;
      err_d[wptr_q]  = ld_bad;
      data_d[wptr_q] = ld_bad ? 64'd0 : mem[ld_off[AW-1:3]];
      age_d[wptr_q]  = 4'd0;
    end
  end
  always_comb begin
    state_d = state_q;
    st_we   = 1'b0;
    if (state_q == S_IDLE) begin
      state_d = dmem.st_valid ? S_RESP : S_IDLE;
      st_we   = dmem.st_valid && st_in;
    end else begin
      state_d = dmem.st_resp_ready ? S_IDLE : S_RESP;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    err_q  <= err_d;
    data_q <= data_d;
    age_q  <= age_d;
    if (st_we)
      for (int i = 0; i < 8; i++)
        if (dmem.st_wstrb[i]) mem[st_off[AW-1:3]][8*i +: 8] <= dmem.st_wdata[8*i +: 8];
  end
  a_ld_stable: assert property (@(posedge clk) disable iff (!rst_n)
    dmem.ld_valid && !dmem.ld_ready |=> dmem.ld_valid && $stable({dmem.ld_addr, dmem.ld_size, dmem.ld_tag}));
  a_st_stable: assert property (@(posedge clk) disable iff (!rst_n)
    dmem.st_valid && !dmem.st_ready |=> dmem.st_valid && $stable({dmem.st_addr, dmem.st_size, dmem.st_wdata, dmem.st_wstrb}));
  a_st_size: assert property (@(posedge clk) disable iff (!rst_n)
    dmem.st_valid |-> dmem.st_size <= 3'd3);
  a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({dmem.ld_valid, dmem.ld_ready, dmem.ld_resp_valid, dmem.ld_resp_ready,
                 dmem.st_valid, dmem.st_ready, dmem.st_resp_valid, dmem.st_resp_ready}));
endmodule

// File: tb/tb_dmem_slave_mem.sv
// tb_dmem_slave_mem: directed scenario checks of loads, stores, errors, ordering and reset
module tb_dmem_slave_mem;
  logic clk;
  logic rst_n;
  int n_chk;
  int n_fail;
  logic [3:0]  r_tag;
  logic [63:0] r_data;
  logic        r_err;
  int          r_lat;
  bit          st_ok;
  dmem_if #(.LDTAG_W(4)) bus ();
  dmem_slave_mem #(
    .MEM_BYTES(4096), .BASE_ADDR(32'h0), .LDTAG_W(4), .LD_LATENCY(2), .LD_DEPTH(4)
  ) dut (.clk(clk), .rst_n(rst_n), .dmem(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    bus.st_valid = 1'b1; bus.st_addr = a; bus.st_size = 3'd3; bus.st_wdata = d; bus.st_wstrb = s;
    tick();
    bus.st_valid = 1'b0;
    st_ok = bus.st_resp_valid && !bus.st_ready;
    bus.st_resp_ready = 1'b1;
    tick();
    bus.st_resp_ready = 1'b0;
    st_ok = st_ok && bus.st_ready && !bus.st_resp_valid;
  endtask
  task automatic wait_resp();
    r_lat = 0;
    while (!bus.ld_resp_valid && r_lat < 20) begin
      tick();
      r_lat++;
    end
    r_tag = bus.ld_resp_tag; r_data = bus.ld_resp_data; r_err = bus.ld_resp_err;
    tick();
  endtask
  task automatic do_load(input logic [31:0] a, input logic [2:0] sz, input logic [3:0] t);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_size = sz; bus.ld_tag = t;
    tick();
    bus.ld_valid = 1'b0;
    wait_resp();
  endtask
  task automatic test_reset();
    n_chk++;
    if ({bus.ld_ready, bus.ld_resp_valid, bus.ld_resp_tag, bus.ld_resp_data, bus.ld_resp_err, bus.st_ready, bus.st_resp_valid}
        !== {1'b1, 1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ldr=%b lrv=%b tag=%h data=%h err=%b str=%b srv=%b want 1 0 0 0 0 1 0",
               bus.ld_ready, bus.ld_resp_valid, bus.ld_resp_tag, bus.ld_resp_data, bus.ld_resp_err, bus.st_ready, bus.st_resp_valid);
    end
  endtask
  task automatic test_store_load();
    do_store(32'h100, 64'h1122334455667788, 8'hFF);
    n_chk++; if (st_ok !== 1'b1) begin n_fail++; $display("FAIL store_handshake: got %b want 1", st_ok); end
    do_load(32'h104, 3'd2, 4'd3);
    n_chk++; if (r_lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d want 2", r_lat); end
    n_chk++; if (r_tag !== 4'd3) begin n_fail++; $display("FAIL load_tag: got %h want 3", r_tag); end
    n_chk++; if (r_data !== 64'h1122334455667788) begin n_fail++; $display("FAIL load_data: got %h want 1122334455667788", r_data); end
    n_chk++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b want 0", r_err); end
  endtask
  task automatic test_partial();
    do_store(32'h100, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0C);
    do_load(32'h100, 3'd3, 4'd5);
    n_chk++; if (r_data !== 64'h11223344AAAA7788) begin n_fail++; $display("FAIL partial_data: got %h want 11223344aaaa7788", r_data); end
    n_chk++; if (r_tag !== 4'd5) begin n_fail++; $display("FAIL partial_tag: got %h want 5", r_tag); end
  endtask
  task automatic test_back_to_back();
    bus.ld_resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h100; bus.ld_size = 3'd3; bus.ld_tag = 4'(k);
      tick();
    end
    bus.ld_valid = 1'b0;
    n_chk++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", bus.ld_ready); end
    tick();
    tick();
    bus.ld_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({bus.ld_resp_valid, bus.ld_resp_tag} !== {1'b1, 4'(k)}) begin
        n_fail++;
        $display("FAIL b2b_order%0d: got valid=%b tag=%h want valid=1 tag=%h", k, bus.ld_resp_valid, bus.ld_resp_tag, 4'(k));
      end
      tick();
    end
    n_chk++;
    if ({bus.ld_ready, bus.ld_resp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_drained: got ready=%b valid=%b want 1 0", bus.ld_ready, bus.ld_resp_valid);
    end
  endtask
  task automatic test_errors();
    do_load(32'h101, 3'd1, 4'd1);
    n_chk++; if ({r_err, r_data} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL err_misaligned: got err=%b data=%h want 1 0", r_err, r_data); end
    do_load(32'h1000, 3'd2, 4'd2);
    n_chk++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL err_out_of_range: got %b want 1", r_err); end
    do_load(32'h100, 3'd5, 4'd4);
    n_chk++; if ({r_err, r_data, r_tag} !== {1'b1, 64'h0, 4'd4}) begin n_fail++; $display("FAIL err_bad_size: got err=%b data=%h tag=%h want 1 0 4", r_err, r_data, r_tag); end
    do_load(32'h104, 3'd2, 4'd6);
    n_chk++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL err_aligned_word: got %b want 0", r_err); end
    do_store(32'h1100, 64'h0, 8'hFF);
    n_chk++; if (st_ok !== 1'b1) begin n_fail++; $display("FAIL oor_store_handshake: got %b want 1", st_ok); end
    do_load(32'h100, 3'd3, 4'd7);
    n_chk++; if (r_data !== 64'h11223344AAAA7788) begin n_fail++; $display("FAIL oor_store_nowrite: got %h want 11223344aaaa7788", r_data); end
  endtask
  task automatic test_same_edge();
    do_store(32'h200, 64'h0, 8'hFF);
    bus.st_valid = 1'b1; bus.st_addr = 32'h200; bus.st_size = 3'd3; bus.st_wdata = 64'hDEADBEEFCAFEF00D; bus.st_wstrb = 8'hFF;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h200; bus.ld_size = 3'd3; bus.ld_tag = 4'd8;
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b0;
    bus.st_resp_ready = 1'b1;
    wait_resp();
    bus.st_resp_ready = 1'b0;
    n_chk++; if ({r_lat, r_data} !== {32'd2, 64'h0}) begin n_fail++; $display("FAIL same_edge_old: got lat=%0d data=%h want 2 0", r_lat, r_data); end
    do_load(32'h200, 3'd3, 4'd9);
    n_chk++; if (r_data !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL same_edge_new: got %h want deadbeefcafef00d", r_data); end
  endtask
  task automatic test_mid_reset();
    bus.ld_resp_ready = 1'b0;
    bus.st_valid = 1'b1; bus.st_addr = 32'h300; bus.st_size = 3'd3; bus.st_wdata = 64'h0123456789ABCDEF; bus.st_wstrb = 8'hFF;
    tick();
    bus.st_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h100; bus.ld_size = 3'd3; bus.ld_tag = 4'(9 + k);
      tick();
    end
    bus.ld_valid = 1'b0;
    tick();
    n_chk++;
    if ({bus.ld_resp_valid, bus.st_resp_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got lrv=%b srv=%b want 1 1", bus.ld_resp_valid, bus.st_resp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    bus.ld_resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if ({bus.ld_ready, bus.st_ready, bus.ld_resp_valid, bus.st_resp_valid} !== 4'b1100) begin
        n_fail++;
        $display("FAIL post_reset_idle%0d: got ldr=%b str=%b lrv=%b srv=%b want 1 1 0 0", k,
                 bus.ld_ready, bus.st_ready, bus.ld_resp_valid, bus.st_resp_valid);
      end
      tick();
    end
    do_load(32'h300, 3'd3, 4'd11);
    n_chk++;
    if ({r_tag, r_data} !== {4'd11, 64'h0123456789ABCDEF}) begin
      n_fail++;
      $display("FAIL store_survives_reset: got tag=%h data=%h want b 0123456789abcdef", r_tag, r_data);
    end
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_size = '0; bus.ld_tag = '0; bus.ld_resp_ready = 1'b1;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_size = '0; bus.st_wdata = '0; bus.st_wstrb = '0; bus.st_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_store_load();
    test_partial();
    test_back_to_back();
    test_errors();
    test_same_edge();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_slave_mem.md
Name: dmem_slave_mem

Overview:
- Behavioural-synthesizable data-memory responder on the slave side of dmem_if. It pairs with the core's LSU, which is the dmem_if master.
- Serves loads through a tagged, fixed-latency, in-order response queue.
- Serves stores with a single-outstanding request/response handshake.
- Backing store is a 64-bit-wide byte-strobed array. The block is used in core-level simulation and FPGA bring-up.

Parameters:
- MEM_BYTES, 4096: backing store size in bytes. Must be a power of 2 and a multiple of 8.
- BASE_ADDR, 32'h0000_0000: address of byte 0. Must be MEM_BYTES-aligned.
- LDTAG_W, 4: load tag width. Must match the connected dmem_if instance.
- LD_LATENCY, 2: cycles from load accept edge to earliest ld_resp_valid. Range 1..15.
- LD_DEPTH, 4: maximum in-flight loads in the response queue. Power of 2, 2..16.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dmem  dmem_if.slave  —  load request/response and store request/response bundle. Parameterised with LDTAG_W.

Behaviour:
- Handshakes:
  - A transfer occurs on a rising edge where valid&&ready.
  - Once valid is asserted it holds until accepted, with payload stable.
- ld_size / st_size encoding: 0=byte, 1=half, 2=word, 3=double. Other codes are illegal and raise an error.
- Address map:
  - off = addr - BASE_ADDR. In range iff off < MEM_BYTES.
  - Doubleword index = off[log2(MEM_BYTES)-1:3].
- Load accept:
  - ld_ready = (q_count != LD_DEPTH). This is combinational from the registered count.
  - There is no same-cycle pop-to-push pass-through.
  - On accept, the block pushes {tag, err, data, age=0} into a circular queue.
  - data is the full aligned 64-bit doubleword, read at the accept edge.
  - Read-before-write: a store accepted on the same edge is not visible to that load.
  - err=1 if the load is out of range, misaligned (off mod (1<<size) != 0), or uses an illegal size. When err=1, data=0.
- Load response:
  - Each queue entry's age increments every cycle, saturating at LD_LATENCY.
  - ld_resp_valid = queue nonempty && head.age == LD_LATENCY.
  - ld_resp_tag, ld_resp_data and ld_resp_err come from the head entry.
  - Pop on ld_resp_valid && ld_resp_ready.
  - Back-to-back loads with ready held high produce one response per cycle, in order.
  - Tags are echoed unmodified. Duplicate tags are legal.
- Store FSM, states S_IDLE and S_RESP:
  - st_ready = (state == S_IDLE).
  - In S_IDLE, on st_valid: write bytes i where st_wstrb[i]=1 with st_wdata[8i+7:8i] at the doubleword index of st_addr. st_addr[2:0] is ignored for placement. Then go to S_RESP.
  - In S_RESP: st_resp_valid=1. On st_resp_ready go to S_IDLE, so st_ready returns the next cycle.
  - An out-of-range store writes nothing but still completes the handshake. There is no store error signal.
  - st_size is checked only for assertion purposes.
- Simultaneous events:
  - Load push and pop on the same edge leave q_count unchanged and both pointers advance.
  - The load and store paths are fully independent.
- Pointer wrap: pointers are log2(LD_DEPTH) bits and wrap modulo LD_DEPTH. Full vs empty is resolved by a (log2(LD_DEPTH)+1)-bit q_count.
- Reset values (async, applied mid-operation too):
  - q_count=0, pointers=0, state=S_IDLE.
  - Outputs: ld_ready=1, ld_resp_valid=0, ld_resp_tag=0, ld_resp_data=0, ld_resp_err=0, st_ready=1, st_resp_valid=0.
  - In-flight loads and a pending store response are discarded. A store already written stays written.
  - Memory array contents are not reset.
- Simulation assertions:
  - Payload stable while valid && !ready on both request channels.
  - No X on any handshake signal after reset release.

Test Plan:
- Store 0x1122334455667788 to 0x100 with wstrb=0xFF → st_resp_valid the cycle after accept. Then LW 0x104 with tag 3 → response exactly LD_LATENCY cycles after accept: tag=3, data=0x1122334455667788, err=0.
- Partial strobe: store wdata=0xAAAA…AA, wstrb=0x0C to 0x100, then load 0x100 → data=0x11223344AAAA7788.
- Four loads in consecutive cycles with tags 0..3 and ld_resp_ready=0 → ld_ready drops after the 4th accept. Raise ready → tags 0,1,2,3 in order on consecutive cycles, then ld_ready=1.
- Errors:
  - LH 0x101 → err=1, data=0.
  - LW at BASE_ADDR+MEM_BYTES → err=1.
  - ld_size=5 → err=1.
  - Store to an out-of-range address → completes handshake and memory is unchanged.
- Same-edge store and load to 0x200 (old contents 0) → load returns 0, and a following load returns the new data.
- Assert rst_n=0 with 2 loads queued and a store in S_RESP → all outputs at reset values immediately. After release, ld_ready=1, st_ready=1, and no stale responses appear.
